// File: rtl/dcache_mem_responder_if.sv
// Request/response bundle between a data cache and its backing-memory responder.
interface dcache_mem_responder_if;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic         ret_last;
  logic [31:0]  ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic         wr_done;

  modport master (
    output rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    input  rd_rdy, ret_valid, ret_last, ret_data, wr_rdy, wr_done
  );

  modport slave (
    input  rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    output rd_rdy, ret_valid, ret_last, ret_data, wr_rdy, wr_done
  );
endinterface

// File: rtl/dcache_mem_responder.sv
// Single-outstanding cache memory model: reads beat out after RD_LATENCY, writes commit after WR_LATENCY.
// Accepts only when idle (read wins over write); DCACHE_RESP_RANDOM_STALL_EN adds LFSR-driven rdy stalls.
module dcache_mem_responder #(
  parameter int MEM_WORDS  = 1024,
  parameter int RD_LATENCY = 2,
  parameter int WR_LATENCY = 2
) (
  input logic                  clk,
  input logic                  rst,
  dcache_mem_responder_if.slave bus
);
  localparam int IDX_W   = $clog2(MEM_WORDS);
  localparam int LAT_MAX = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);
  localparam logic [2:0] TYPE_LINE = 3'b100;

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BEAT, WR_WAIT, WR_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         beat_q, beat_d;
  logic [IDX_W-1:0]   idx_q;
  logic               line_q;
  logic [3:0]         wstrb_q;
  logic [127:0]       wdata_q;
  logic [31:0]        mem [MEM_WORDS];

  logic               stall_ok;
  logic               rd_rdy_int, wr_rdy_int;
  logic               rd_acc, wr_acc;
  logic               last_beat;
  logic               commit;
  logic [IDX_W-1:0]   rd_idx_in, wr_idx_in;
  logic [IDX_W-1:0]   beat_idx;

`ifdef DCACHE_RESP_RANDOM_STALL_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 8'hA5;
    else     lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign stall_ok = lfsr_q[0];
`else
  assign stall_ok = 1'b1;
`endif

  // Address bits outside the word index are deliberately ignored (modulo wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.rd_addr[31:IDX_W+2], bus.rd_addr[1:0],
                              bus.wr_addr[31:IDX_W+2], bus.wr_addr[1:0]};

  assign rd_idx_in  = (bus.rd_type == TYPE_LINE) ? {bus.rd_addr[IDX_W+1:4], 2'b00} : bus.rd_addr[2 +: IDX_W];
  assign wr_idx_in  = (bus.wr_type == TYPE_LINE) ? {bus.wr_addr[IDX_W+1:4], 2'b00} : bus.wr_addr[2 +: IDX_W];
  assign rd_rdy_int = (state_q == IDLE) && stall_ok;
  assign wr_rdy_int = (state_q == IDLE) && stall_ok && !bus.rd_req;
  assign rd_acc     = bus.rd_req && rd_rdy_int;
  assign wr_acc     = bus.wr_req && wr_rdy_int;
  assign last_beat  = !line_q || (beat_q == 2'd3);
  assign beat_idx   = idx_q + IDX_W'(beat_q);
  // Reset on the commit edge wins, so an aborted write never lands.
  assign commit     = (state_q == WR_WAIT) && (cnt_q == '0) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      idx_q   <= '0;
      line_q  <= 1'b0;
      wstrb_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      if (rd_acc) begin
        idx_q  <= rd_idx_in;
        line_q <= (bus.rd_type == TYPE_LINE);
      end else if (wr_acc) begin
        idx_q   <= wr_idx_in;
        line_q  <= (bus.wr_type == TYPE_LINE);
        wstrb_q <= bus.wr_wstrb;
        wdata_q <= bus.wr_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (rd_acc) begin
          state_d = RD_WAIT;
          cnt_d   = CNT_W'(RD_LATENCY - 1);
        end else if (wr_acc) begin
          state_d = WR_WAIT;
          cnt_d   = CNT_W'(WR_LATENCY - 1);
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          state_d = RD_BEAT;
          beat_d  = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RD_BEAT: begin
        if (last_beat) state_d = IDLE;
        else           beat_d  = beat_q + 1'b1;
      end
      WR_WAIT: begin
        if (cnt_q == '0) state_d = WR_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      WR_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.rd_rdy    = rd_rdy_int;
    bus.wr_rdy    = wr_rdy_int;
    bus.ret_valid = 1'b0;
    bus.ret_last  = 1'b0;
    bus.ret_data  = '0;
    bus.wr_done   = 1'b0;
    case (state_q)
      RD_BEAT: begin
        bus.ret_valid = 1'b1;
        bus.ret_last  = last_beat;
        bus.ret_data  = mem[beat_idx];
      end
      WR_DONE: bus.wr_done = 1'b1;
      default: ;
    endcase
  end

  // Backing store has no reset so contents survive a transaction abort.
  always_ff @(posedge clk) begin
    if (commit) begin
      if (line_q) begin
        for (int i = 0; i < 4; i++)
          mem[{idx_q[IDX_W-1:2], 2'(i)}] <= wdata_q[32*i +: 32];
      end else begin
        for (int b = 0; b < 4; b++)
          if (wstrb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dcache_mem_responder.sv
// Randomized bench for dcache_mem_responder against a word-array reference model.
module tb_dcache_mem_responder;
  localparam int MEM_WORDS  = 1024;
  localparam int RD_LATENCY = 2;
  localparam int WR_LATENCY = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_mem_responder_if bus();

  dcache_mem_responder #(
    .MEM_WORDS (MEM_WORDS),
    .RD_LATENCY(RD_LATENCY),
    .WR_LATENCY(WR_LATENCY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_run = 0;
  int n_fail = 0;
  int n_done_seen = 0;
  int n_last_seen = 0;
  int n_wr_exp = 0;
  int n_rd_exp = 0;
  logic [31:0] model_mem [MEM_WORDS];
  logic [31:0] rd_beats [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic int unsigned widx(input logic [31:0] a);
    return (a / 4) % MEM_WORDS;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [2:0] t,
                                      input logic [3:0] s, input logic [127:0] d);
    int unsigned base;
    if (t == 3'b100) begin
      base = widx(a) - (widx(a) % 4);
      for (int i = 0; i < 4; i++) model_mem[base + i] = d[32*i +: 32];
    end else begin
      for (int b = 0; b < 4; b++)
        if (s[b]) model_mem[widx(a)][8*b +: 8] = d[8*b +: 8];
    end
  endfunction

  always @(negedge clk) begin
    if (bus.wr_done === 1'b1) n_done_seen++;
    if (bus.ret_valid === 1'b1 && bus.ret_last === 1'b1) n_last_seen++;
  end

  task automatic do_write(input logic [31:0] a, input logic [2:0] t,
                          input logic [3:0] s, input logic [127:0] d);
    int cyc;
    @(negedge clk);
    bus.wr_req = 1'b1; bus.wr_addr = a; bus.wr_type = t; bus.wr_wstrb = s; bus.wr_data = d;
    cyc = 0;
    while (bus.wr_rdy !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
    if (bus.wr_rdy !== 1'b1) begin
      chk("wr_accept", {31'd0, bus.wr_rdy}, 32'd1);
      bus.wr_req = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.wr_req = 1'b0;
    cyc = 0;
    while (bus.wr_done !== 1'b1 && cyc < 64) begin @(posedge clk); #1; cyc++; end
    chk("wr_latency", cyc, WR_LATENCY);
    model_write(a, t, s, d);
    n_wr_exp++;
    @(posedge clk); #1;
    chk("wr_done_pulse", {31'd0, bus.wr_done}, 32'd0);
  endtask

  // mode 0: plain, 1: write raised together with the read, 2: write raised while busy
  task automatic do_read(input logic [31:0] a, input logic [2:0] t, input int mode);
    int cyc, nb;
    int unsigned base;
    @(negedge clk);
    bus.rd_req = 1'b1; bus.rd_addr = a; bus.rd_type = t;
    if (mode == 1) begin
      bus.wr_req = 1'b1; bus.wr_addr = a; bus.wr_type = 3'b100; bus.wr_wstrb = 4'hF;
      bus.wr_data = {$urandom, $urandom, $urandom, $urandom};
      #1;
      chk("simul_wr_rdy", {31'd0, bus.wr_rdy}, 32'd0);
    end
    cyc = 0;
    while (bus.rd_rdy !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
    if (bus.rd_rdy !== 1'b1) begin
      chk("rd_accept", {31'd0, bus.rd_rdy}, 32'd1);
      bus.rd_req = 1'b0; bus.wr_req = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
    n_rd_exp++;
    if (mode == 2) begin
      bus.wr_req = 1'b1; bus.wr_addr = a; bus.wr_type = 3'b010; bus.wr_wstrb = 4'hF;
      bus.wr_data = {4{~model_mem[widx(a)]}};
    end
    cyc = 0;
    while (bus.ret_valid !== 1'b1 && cyc < 64) begin @(posedge clk); #1; cyc++; end
    bus.wr_req = 1'b0;
    chk("rd_latency", cyc, RD_LATENCY);
    nb   = (t == 3'b100) ? 4 : 1;
    base = (t == 3'b100) ? widx(a) - (widx(a) % 4) : widx(a);
    for (int i = 0; i < nb; i++) begin
      rd_beats[i] = bus.ret_data;
      chk("rd_valid", {31'd0, bus.ret_valid}, 32'd1);
      chk("rd_data", bus.ret_data, model_mem[base + i]);
      chk("rd_last", {31'd0, bus.ret_last}, (i == nb - 1) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
    chk("rd_after_valid", {31'd0, bus.ret_valid}, 32'd0);
    chk("rd_after_data", bus.ret_data, 32'd0);
`ifndef DCACHE_RESP_RANDOM_STALL_EN
    chk("rd_after_rdy", {31'd0, bus.rd_rdy}, 32'd1);
`endif
  endtask

  initial begin
    int seen;
    logic [31:0] a;
    logic [2:0]  t;

    bus.rd_req = 1'b0; bus.rd_type = '0; bus.rd_addr = '0;
    bus.wr_req = 1'b0; bus.wr_type = '0; bus.wr_addr = '0; bus.wr_wstrb = '0; bus.wr_data = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ret_valid", {31'd0, bus.ret_valid}, 32'd0);
    chk("rst_ret_last", {31'd0, bus.ret_last}, 32'd0);
    chk("rst_ret_data", bus.ret_data, 32'd0);
    chk("rst_wr_done", {31'd0, bus.wr_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_rd_rdy", {31'd0, bus.rd_rdy}, 32'd1);
    chk("rst_wr_rdy", {31'd0, bus.wr_rdy}, 32'd1);

    // Fill the whole memory so every later read has a known value.
    for (int l = 0; l < MEM_WORDS / 4; l++)
      do_write(32'(l * 16), 3'b100, 4'($urandom), {$urandom, $urandom, $urandom, $urandom});

    do_write(32'h10, 3'b100, 4'h0, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
    do_read(32'h18, 3'b100, 0);
    chk("line_beat0", rd_beats[0], 32'h11111111);
    chk("line_beat1", rd_beats[1], 32'h22222222);
    chk("line_beat2", rd_beats[2], 32'h33333333);
    chk("line_beat3", rd_beats[3], 32'h44444444);

    do_write(32'h20, 3'b010, 4'hF, 128'h0);
    do_write(32'h20, 3'b010, 4'b0101, {96'h0, 32'hDEADBEEF});
    do_read(32'h20, 3'b010, 0);
    chk("wstrb_merge", rd_beats[0], 32'h00AD00EF);

    do_write(32'h20, 3'b000, 4'b0000, {4{32'hCAFEF00D}});
    do_read(32'h22, 3'b001, 0);
    chk("wstrb_zero", rd_beats[0], 32'h00AD00EF);

    do_read(32'h30, 3'b010, 1);
    do_read(32'h30, 3'b100, 0);

    // Line write aborted by reset while waiting to commit.
    @(negedge clk);
    bus.wr_req = 1'b1; bus.wr_addr = 32'h40; bus.wr_type = 3'b100; bus.wr_wstrb = 4'hF;
    bus.wr_data = {4{32'hBADC0FFE}};
    @(posedge clk); #1;
    bus.wr_req = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_rd_rdy", {31'd0, bus.rd_rdy}, 32'd1);
    seen = 0;
    for (int i = 0; i < WR_LATENCY + 3; i++) begin
      if (bus.wr_done === 1'b1) seen++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", seen, 0);
    do_read(32'h40, 3'b100, 0);

    // Read aborted by reset must never produce a beat.
    @(negedge clk);
    bus.rd_req = 1'b1; bus.rd_addr = 32'h50; bus.rd_type = 3'b100;
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < RD_LATENCY + 6; i++) begin
      if (bus.ret_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    chk("abort_no_beat", seen, 0);

    do_read(32'h0000_1000, 3'b010, 0);
    chk("wrap_word0", rd_beats[0], model_mem[0]);
    do_read(32'hFFFF_F00C, 3'b100, 0);

    for (int n = 0; n < 200; n++) begin
      a = $urandom;
      t = 3'($urandom);
      if ($urandom_range(0, 1) == 0)
        do_read(a, t, $urandom_range(0, 2));
      else
        do_write(a, ($urandom_range(0, 1) == 0) ? 3'b100 : t, 4'($urandom),
                 {$urandom, $urandom, $urandom, $urandom});
    end

    repeat (4) @(posedge clk);
    #1;
    chk("wr_done_count", n_done_seen, n_wr_exp);
    chk("ret_last_count", n_last_seen, n_rd_exp);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dcache_mem_responder.md
DCACHE_MEM_RESPONDER -- requirements
Module: dcache_mem_responder

Interface
REQ-001 Parameter MEM_WORDS, default 1024, depth of backing memory in 32-bit words (power of two).
REQ-002 Parameter RD_LATENCY, default 2, cycles from read acceptance to first ret_valid beat (>=1).
REQ-003 Parameter WR_LATENCY, default 2, cycles from write acceptance to wr_done (>=1).
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 rd_req  input  1  read request valid.
REQ-007 rd_type  input  3  000 byte, 001 half, 010 word, 100 cache line (4 words).
REQ-008 rd_addr  input  32  read start byte address.
REQ-009 rd_rdy  output  1  read request can be accepted this cycle.
REQ-010 ret_valid  output  1  read data beat valid.
REQ-011 ret_last  output  1  final beat of current read.
REQ-012 ret_data  output  32  read data beat.
REQ-013 wr_req  input  1  write request valid.
REQ-014 wr_type  input  3  encoding as rd_type.
REQ-015 wr_addr  input  32  write byte address.
REQ-016 wr_wstrb  input  4  byte enables for non-line writes.
REQ-017 wr_data  input  128  write data; word i = wr_data[32i+31:32i].
REQ-018 wr_rdy  output  1  write request can be accepted this cycle.
REQ-019 wr_done  output  1  one-cycle pulse: write committed to memory.

Function
REQ-020 FSM states: IDLE, RD_WAIT, RD_BEAT, WR_WAIT, WR_DONE; rd_rdy and wr_rdy SHALL be high only in IDLE (subject to REQ-034).
REQ-021 Request accepted when req and matching rdy both high on a clock edge; requests while rdy low SHALL be ignored, not queued.
REQ-022 Simultaneous rd_req and wr_req in IDLE: read accepted, write ignored; wr_rdy SHALL be low in that cycle.
REQ-023 Read accept: latch rd_addr/rd_type, load latency counter with RD_LATENCY-1, go RD_WAIT (counter 0 -> RD_BEAT).
REQ-024 Word index = addr[2 +: log2(MEM_WORDS)]; higher address bits ignored (modulo wrap).
REQ-025 rd_type 100: four beats on consecutive cycles from line-aligned index (addr[3:2] forced 00), ascending; ret_last on 4th beat only.
REQ-026 Any other rd_type (000/001/010 and reserved 011/101/110/111): one beat, full aligned 32-bit word, ret_last=1.
REQ-027 After the ret_last beat FSM SHALL return to IDLE; next request acceptable the following cycle.
REQ-028 ret_valid, ret_last, ret_data SHALL be 0 whenever not in a beat cycle.
REQ-029 Write accept: latch addr/type/wstrb/data, counter WR_LATENCY-1, go WR_WAIT; memory updated on the edge leaving WR_WAIT.
REQ-030 wr_type 100: write all four words to line-aligned indices, all bytes enabled, wr_wstrb ignored.
REQ-031 Other wr_type: write wr_data[31:0] to the word index, bytes per wr_wstrb; wr_wstrb=0000 SHALL leave memory unchanged but still complete.
REQ-032 WR_DONE: wr_done=1 for exactly one cycle, then IDLE.
REQ-033 A read accepted the cycle after wr_done SHALL return the newly written data.

Reset
REQ-034 On rst: state IDLE, counters 0, ret_valid/ret_last/wr_done 0, ret_data 0, rd_rdy/wr_rdy 1 in the following cycle (stall macro off).
REQ-035 rst mid-read or mid-write SHALL abort the transaction; an uncommitted write SHALL NOT modify memory; memory contents SHALL NOT be cleared.

Configuration
REQ-036 Macro DCACHE_RESP_RANDOM_STALL_EN: when defined, 8-bit Fibonacci LFSR (taps 8,6,5,4), reset to 8'hA5, advancing every cycle; rd_rdy and wr_rdy additionally ANDed with lfsr[0].
REQ-037 When undefined: no LFSR logic; rd_rdy/wr_rdy = (state==IDLE) per REQ-020/022.

Verification
REQ-038 Preload word[4]=32'h11111111..word[7]=32'h44444444; line read rd_addr=32'h18 -> beats 1111..,2222..,3333..,4444.. starting RD_LATENCY cycles after accept, ret_last on beat 4.
REQ-039 Word write addr 32'h20, data 32'hDEADBEEF, wstrb 0101, old 32'h00000000 -> wr_done after WR_LATENCY cycles; subsequent word read returns 32'h00AD00EF.
REQ-040 rd_req and wr_req same cycle in IDLE -> read served, memory unchanged by the write, wr_rdy low that cycle.
REQ-041 rst asserted during line-write WR_WAIT to addr 32'h40 -> no wr_done, later read of 32'h40 returns pre-write value, rd_rdy high cycle after rst release.
REQ-042 Read addr 32'h0000_1000 with MEM_WORDS=1024 -> returns word[0] (wrap).
REQ-043 With DCACHE_RESP_RANDOM_STALL_EN: 200 random requests -> no accept when rdy low, every accepted request completes exactly once.
